// File: rtl/iir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iir_pkg : shared types and constants for the sequential biquad       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package iir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int COEF_FRAC = 22;

  // Accumulator needs 3 guard bits above a full product for the five terms
  function automatic int acc_width(input int wd_in, input int co_wd);
    return wd_in + co_wd + 3;
  endfunction

  // Term order through the single multiplier
  localparam logic [2:0] SEL_B0 = 3'd0;
  localparam logic [2:0] SEL_B1 = 3'd1;
  localparam logic [2:0] SEL_B2 = 3'd2;
  localparam logic [2:0] SEL_A1 = 3'd3;
  localparam logic [2:0] SEL_A2 = 3'd4;

endpackage
`default_nettype wire

// File: rtl/iir_round_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iir_round_sat : round-half-up, shift by FRAC, saturate to OUT_WD     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module iir_round_sat #(
  parameter int IN_WD  = 51,
  parameter int OUT_WD = 24,
  parameter int FRAC   = 22
) (
  input  logic signed [IN_WD-1:0]  acc,
  output logic signed [OUT_WD-1:0] y,
  output logic                     ovf
);

  localparam int SH_WD = IN_WD - FRAC;
  localparam logic [IN_WD-1:0] HALF = {{(IN_WD-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [SH_WD-1:0] MAXV = SH_WD'({1'b0, {(OUT_WD-1){1'b1}}});
  localparam logic signed [SH_WD-1:0] MINV = ~MAXV;

  logic signed [IN_WD-1:0] biased;
  logic signed [SH_WD-1:0] shifted;

  assign biased  = acc + signed'(HALF);
  assign shifted = SH_WD'(biased >>> FRAC);

  always_comb begin
    y   = shifted[OUT_WD-1:0];
    ovf = 1'b0;
    if (shifted > MAXV) begin
      y   = MAXV[OUT_WD-1:0];
      ovf = 1'b1;
    end else if (shifted < MINV) begin
      y   = MINV[OUT_WD-1:0];
      ovf = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/iir_biquad_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iir_biquad_seq : Direct Form I biquad, one shared multiplier,        |
// | one sample per 7 clocks with valid/ready input handshake. rev 1.0    |
// +----------------------------------------------------------------------+
module iir_biquad_seq
  import iir_pkg::*;
#(
  parameter int               WD_IN  = 24,
  parameter int               WD_OUT = 24,
  parameter int               CO_WD  = 24,
  parameter logic [CO_WD-1:0] B0     = 24'h400000,
  parameter logic [CO_WD-1:0] B1     = 24'h000000,
  parameter logic [CO_WD-1:0] B2     = 24'h000000,
  parameter logic [CO_WD-1:0] A1     = 24'h000000,
  parameter logic [CO_WD-1:0] A2     = 24'h000000
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              valid_i,
  input  logic [WD_IN-1:0]  data_i,
  output logic              ready_o,
  input  logic              flush_i,
  output logic [WD_OUT-1:0] data_o,
  output logic              valid_o,
  output logic              sat_o
);

  localparam int ACC_WD = acc_width(WD_IN, CO_WD);
  localparam int OP_WD  = (WD_IN > WD_OUT) ? WD_IN : WD_OUT;
  localparam int PR_WD  = OP_WD + CO_WD;

  state_t state, state_nx;
  logic [2:0] cnt;
  logic signed [WD_IN-1:0]  x0, x1, x2;
  logic signed [WD_OUT-1:0] y1, y2;
  logic signed [ACC_WD-1:0] acc;
  logic signed [CO_WD-1:0]  coef;
  logic signed [OP_WD-1:0]  op;
  logic signed [PR_WD-1:0]  prod;
  logic signed [ACC_WD-1:0] prod_ext;
  logic                     sub;
  logic signed [WD_OUT-1:0] y_new;
  logic                     ovf;
  logic                     accept, mac_en, out_en;

  // State register
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = MAC;
      MAC:     if (cnt == SEL_A2) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control outputs
  always_comb begin
    ready_o = (state == IDLE) && !clr_i;
    accept  = valid_i && ready_o;
    mac_en  = (state == MAC);
    out_en  = (state == DONE);
  end

  // Coefficient/operand select; feedback terms are subtracted rather than
  // negating the coefficient, so a1 = -2.0 needs no extra bit.
  always_comb begin
    coef = signed'(B0);
    op   = OP_WD'(x0);
    sub  = 1'b0;
    case (cnt)
      SEL_B0: begin coef = signed'(B0); op = OP_WD'(x0); end
      SEL_B1: begin coef = signed'(B1); op = OP_WD'(x1); end
      SEL_B2: begin coef = signed'(B2); op = OP_WD'(x2); end
      SEL_A1: begin coef = signed'(A1); op = OP_WD'(y1); sub = 1'b1; end
      SEL_A2: begin coef = signed'(A2); op = OP_WD'(y2); sub = 1'b1; end
      default: ;
    endcase
  end

  assign prod     = coef * op;
  assign prod_ext = ACC_WD'(prod);

  iir_round_sat #(
    .IN_WD  (ACC_WD),
    .OUT_WD (WD_OUT),
    .FRAC   (COEF_FRAC)
  ) u_round_sat (
    .acc (acc),
    .y   (y_new),
    .ovf (ovf)
  );

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      cnt     <= 3'd0;
      acc     <= '0;
      x0      <= '0;
      x1      <= '0;
      x2      <= '0;
      y1      <= '0;
      y2      <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      sat_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      sat_o   <= 1'b0;
      if (ready_o && flush_i) begin
        x1 <= '0;
        x2 <= '0;
        y1 <= '0;
        y2 <= '0;
      end
      if (accept) begin
        x0  <= data_i;
        acc <= '0;
        cnt <= 3'd0;
      end
      if (mac_en) begin
        acc <= sub ? (acc - prod_ext) : (acc + prod_ext);
        cnt <= cnt + 3'd1;
      end
      if (out_en) begin
        data_o  <= y_new;
        valid_o <= 1'b1;
        sat_o   <= ovf;
        x2      <= x1;
        x1      <= x0;
        y2      <= y1;
        y1      <= y_new;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/iir_biquad_seq.md
# iir_biquad_seq

Second-order IIR section (Direct Form I biquad) complementing the pipelined FIR path: where the FIR is feed-forward only, this block adds the feedback (pole) half of the filter family. It uses one time-multiplexed multiplier and a valid/ready input handshake. It sits in the audio-rate sample chain, and stages cascade for higher orders. One sample is processed per 7 clock cycles.

## Interface
- WD_IN, 24: input sample width, signed.
- WD_OUT, 24: output sample width, signed.
- CO_WD, 24: coefficient width, signed Q2.22.
- B0, 24'h400000: feed-forward coefficient b0. The default is 1.0.
- B1, 24'h000000: feed-forward coefficient b1.
- B2, 24'h000000: feed-forward coefficient b2.
- A1, 24'h000000: feedback coefficient a1, in the denominator 1 + a1·z⁻¹ + a2·z⁻².
- A2, 24'h000000: feedback coefficient a2.
- clk_i  in  1  clock; all state changes on the rising edge.
- clr_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  input sample valid.
- data_i  in  WD_IN  input sample x[n].
- ready_o  out  1  block can accept a sample; equals (state==IDLE) && !clr_i.
- flush_i  in  1  synchronous clear of filter history; honoured in IDLE only.
- data_o  out  WD_OUT  output sample y[n]; held until the next result.
- valid_o  out  1  one-cycle pulse when data_o updates.
- sat_o  out  1  pulse coincident with valid_o when the result saturated.

## Operation
- Difference equation: y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2].
- History registers:
  - x1, x2 hold WD_IN-bit past inputs.
  - y1, y2 hold WD_OUT-bit past outputs.
  - y history stores the post-saturation value.
- FSM states:
  - IDLE: ready_o=1. Accept on valid_i && ready_o: latch x0, clear acc, cnt=0, go to MAC.
  - MAC: one product per cycle, acc += coef[cnt]·op[cnt].
    - Order: b0·x0, b1·x1, b2·x2, −a1·y1, −a2·y2.
    - Go to DONE after cnt==4.
  - DONE:
    - data_o ← sat(round(acc)), valid_o ← 1, sat_o ← overflow.
    - Shift history: x2←x1, x1←x0, y2←y1, y1←new y.
    - Go to IDLE.
- Accumulator width: WD_IN+CO_WD+3 = 51 bits, signed. No overflow is possible within the five terms.
- Rounding: add 2^21, then arithmetic shift right by 22. This is round-half-up, so −1.5 → −1.
- Saturation: clamp to [−2^(WD_OUT−1), 2^(WD_OUT−1)−1] and flag sat_o.
- flush_i:
  - In IDLE: zero x1, x2, y1, y2 at the edge.
  - With valid_i in the same cycle: the sample is also accepted and computed against the zeroed history.
  - Outside IDLE: ignored.
- valid_i while busy: ignored; the sample is not captured.
- Reset values: every register is 0, state=IDLE, data_o=0, valid_o=0, sat_o=0. ready_o=0 while clr_i is high.
- Reset mid-MAC or at DONE: the computation is abandoned, history is cleared, and no valid_o is produced.

## Timing
- Accept edge E0 → MAC edges E1–E5 → output edge E6.
- valid_o is high for exactly the cycle after E6. Latency is 6 clocks from the accept edge.
- ready_o is low from after E0 until after E6. Maximum throughput is 1 sample per 7 cycles.
- A new sample may be accepted in the same cycle valid_o is high.
- No output backpressure: the consumer must take data_o on the valid_o pulse.

## Structure
- Package iir_pkg holds:
  - state enum {IDLE, MAC, DONE};
  - COEF_FRAC=22 and ACC_WD=WD_IN+CO_WD+3;
  - coefficient-select constants.
- Sub-module iir_round_sat: combinational round-half-up, shift and saturate from ACC_WD to WD_OUT, producing an overflow flag. It is reusable by a future FIR rounding stage.
- The top level holds the FSM, counter, operand/coefficient mux, single multiplier, accumulator and history registers.

## Test plan
- Defaults (identity), accept data_i=24'sh100000 → 6 clocks later data_o=24'sh100000 and valid_o high for 1 cycle; next zero input gives 0.
- B0=24'h400000, A1=24'hE00000 (−0.5), impulse 24'sh100000 then zeros → outputs 24'sh100000, 24'sh080000, 24'sh040000, 24'sh020000.
- Saturation with B0=24'h7FFFFF:
  - x=24'sh7FFFFF → data_o=24'sh7FFFFF, sat_o=1.
  - x=24'sh800000 → data_o=24'sh800000, sat_o=1.
- Rounding with B0=24'h200000 (0.5):
  - x=3 → 2.
  - x=−3 → −1 (24'shFFFFFF).
  - x=2 → 1 with sat_o=0.
- Handshake: valid_i held high with incrementing data → one accept every 7 cycles, and ready_o low for 6 cycles after each accept. Samples presented while busy produce no output.
- Feedback config: clr_i pulsed during MAC → no valid_o and all outputs 0. After release, impulse 24'sh100000 → 24'sh100000 (history cleared). flush_i in IDLE after an output, then x=0 → data_o=0.
